// File: rtl/serial_pair_adder_pkg.sv
// Shared types and sizing helpers for the serial pair adder.
// Optional signed-overflow output is enabled by SERIAL_PAIR_ADDER_OVF_EN.
package serial_pair_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 32'sd8;

    // Width of the pair counter: clog2 of the pair count, never below one bit.
    function automatic int pair_cnt_w(input int width);
        int n;
        n = width / 32'sd2;
        return (n < 32'sd2) ? 32'sd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_pair_adder_if.sv
// Start/busy/done handshake and operand/result bus of the serial pair adder.
// The ovf signal exists only when SERIAL_PAIR_ADDER_OVF_EN is defined.
interface serial_pair_adder_if
    import serial_pair_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_PAIR_ADDER_OVF_EN
    logic             ovf;

    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/twobitadder.sv
// Existing verified 2-bit ripple slice: {Cout,Sum} = A + B + Cin.
module twobitadder (
    input  logic [1:0] A,
    input  logic [1:0] B,
    input  logic       Cin,
    output logic [1:0] Sum,
    output logic       Cout
);
    assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {2'b00, Cin};
endmodule

// File: rtl/serial_pair_adder.sv
// WIDTH-bit adder that feeds one bit-pair per cycle through twobitadder, LSB first.
// Define SERIAL_PAIR_ADDER_OVF_EN to add the registered signed-overflow output.
module serial_pair_adder
    import serial_pair_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)(
    input  logic                clk,
    input  logic                rst_n,
    serial_pair_adder_if.slave  bus
);
    localparam int              NUM_PAIRS = WIDTH / 32'sd2;
    localparam int              CNT_W     = pair_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(NUM_PAIRS - 32'sd1);

    state_t           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             carry_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    logic [1:0]       slice_sum_s;
    logic             slice_cout_s;
    logic [WIDTH-1:0] assembled_s;

    twobitadder u_slice (
        .A    (a_sh_r[1:0]),
        .B    (b_sh_r[1:0]),
        .Cin  (carry_r),
        .Sum  (slice_sum_s),
        .Cout (slice_cout_s)
    );

    // New pair enters at the top; after the last pair the LSB pair sits at bit 0.
    assign assembled_s = (acc_r >> 2'd2) | (WIDTH'(slice_sum_s) << (WIDTH - 32'sd2));

`ifdef SERIAL_PAIR_ADDER_OVF_EN
    logic a_msb_r;
    logic b_msb_r;
    logic ovf_r;
    logic ovf_s;

    assign ovf_s   = (a_msb_r == b_msb_r) && (assembled_s[WIDTH-1] != a_msb_r);
    assign bus.ovf = ovf_r;
`endif

    // Handshake FSM, operand sequencing, carry storage and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            a_sh_r  <= '0;
            b_sh_r  <= '0;
            acc_r   <= '0;
            cnt_r   <= '0;
            carry_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
`ifdef SERIAL_PAIR_ADDER_OVF_EN
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            ovf_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_sh_r  <= bus.a;
                        b_sh_r  <= bus.b;
                        carry_r <= bus.cin;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= RUN;
`ifdef SERIAL_PAIR_ADDER_OVF_EN
                        a_msb_r <= bus.a[WIDTH-1];
                        b_msb_r <= bus.b[WIDTH-1];
`endif
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    a_sh_r  <= a_sh_r >> 2'd2;
                    b_sh_r  <= b_sh_r >> 2'd2;
                    acc_r   <= assembled_s;
                    carry_r <= slice_cout_s;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_PAIR) begin
                        sum_r   <= assembled_s;
                        cout_r  <= slice_cout_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
`ifdef SERIAL_PAIR_ADDER_OVF_EN
                        ovf_r   <= ovf_s;
`endif
                    end else begin
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= RUN;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;

endmodule

// File: tb/tb_serial_pair_adder.sv
// Self-checking bench: directed plan plus random adds against an arithmetic reference.
// Overflow checks are compiled in when SERIAL_PAIR_ADDER_OVF_EN is defined.
module tb_serial_pair_adder;
    localparam int W = 8;
    localparam int N = W / 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   passed = 0;
    int   fails  = 0;
    int   e0     = 0;
    int   e0_prev = 0;
    logic [W:0] prev_res = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_pair_adder_if #(.WIDTH(W)) bus ();
    serial_pair_adder_if #(.WIDTH(2)) bus2 ();

    serial_pair_adder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    serial_pair_adder #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return W'(0) + {1'b0, a} + {1'b0, b} + (W+1)'(c);
    endfunction

`ifdef SERIAL_PAIR_ADDER_OVF_EN
    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int s;
        s = int'($signed(a)) + int'($signed(b)) + int'(c);
        return (s > 127) || (s < -128);
    endfunction
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the following posedge is the accepting edge E0.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        bus.start = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.cin = c;
        @(posedge clk);
        #1;
        e0_prev = e0;
        e0 = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int guard;
        logic [W:0] exp;
        guard = 0;
        exp = ref_add(a, b, c);
        chk({tag, "_busy_early"}, 64'(bus.busy), 64'd1);
        while (bus.done !== 1'b1 && guard < 64) begin
            @(negedge clk);
            guard++;
            if (bus.done !== 1'b1) begin
                chk({tag, "_busy_run"}, 64'(bus.busy), 64'd1);
                chk({tag, "_hold"}, 64'({bus.cout, bus.sum}), 64'(prev_res));
            end
        end
        chk({tag, "_done_seen"}, 64'(bus.done), 64'd1);
        chk({tag, "_latency"}, 64'(cyc - e0), 64'(N));
        chk({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
        chk({tag, "_result"}, 64'({bus.cout, bus.sum}), 64'(exp));
`ifdef SERIAL_PAIR_ADDER_OVF_EN
        chk({tag, "_ovf"}, 64'(bus.ovf), 64'(ref_ovf(a, b, c)));
`endif
        prev_res = exp;
    endtask

    initial begin
        int dcount;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_result", 64'({bus.cout, bus.sum}), 64'd0);
        chk("rst_w2", 64'({bus2.busy, bus2.done, bus2.cout, bus2.sum}), 64'd0);
`ifdef SERIAL_PAIR_ADDER_OVF_EN
        chk("rst_ovf", 64'(bus.ovf), 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Plain add, then full carry ripple
        start_op(8'h5A, 8'h3C, 1'b0);
        wait_done("t5a3c", 8'h5A, 8'h3C, 1'b0);
        chk("t5a3c_const", 64'({bus.cout, bus.sum}), 64'h096);
        @(negedge clk);
        chk("idle_after_done", 64'({bus.busy, bus.done}), 64'd0);
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done("tripple", 8'hFF, 8'h01, 1'b0);
        chk("tripple_const", 64'({bus.cout, bus.sum}), 64'h100);
        @(negedge clk);

        // Max operands with carry-in, then back-to-back restart in DONE
        start_op(8'hFF, 8'hFF, 1'b1);
        wait_done("tmax", 8'hFF, 8'hFF, 1'b1);
        chk("tmax_const", 64'({bus.cout, bus.sum}), 64'h1FF);
        start_op(8'h01, 8'h01, 1'b0);
        chk("b2b_period", 64'(e0 - e0_prev), 64'(N + 1));
        wait_done("tb2b", 8'h01, 8'h01, 1'b0);
        chk("tb2b_const", 64'({bus.cout, bus.sum}), 64'h002);
        @(negedge clk);

        // start during RUN is ignored
        start_op(8'h10, 8'h20, 1'b0);
        bus.start = 1'b1;
        bus.a = 8'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = 8'h00;
        wait_done("tign", 8'h10, 8'h20, 1'b0);
        chk("tign_const", 64'({bus.cout, bus.sum}), 64'h030);
        dcount = 0;
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) dcount++;
        end
        chk("tign_single_done", 64'(dcount), 64'd0);

        // Reset during the second RUN cycle
        start_op(8'h33, 8'h44, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_outputs", 64'({bus.busy, bus.done, bus.cout, bus.sum}), 64'd0);
        dcount = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dcount++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < N + 1; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dcount++;
        end
        chk("mrst_no_done", 64'(dcount), 64'd0);
        prev_res = '0;
        start_op(8'hA5, 8'h5A, 1'b1);
        wait_done("tpostrst", 8'hA5, 8'h5A, 1'b1);
        @(negedge clk);

`ifdef SERIAL_PAIR_ADDER_OVF_EN
        start_op(8'h7F, 8'h01, 1'b0);
        wait_done("tovf", 8'h7F, 8'h01, 1'b0);
        chk("tovf_const", 64'({bus.ovf, bus.sum}), 64'h180);
        @(negedge clk);
`endif

        // Random adds, sometimes restarted straight from DONE
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            start_op(ra, rb, rc);
            wait_done("trand", ra, rb, rc);
            if ($urandom_range(1, 0) == 0) @(negedge clk);
        end
        @(negedge clk);

        // WIDTH=2: exhaustive, single RUN cycle, restarted in each DONE cycle
        for (int v = 0; v < 32; v++) begin
            bus2.cin = v[4];
            bus2.a = v[3:2];
            bus2.b = v[1:0];
            bus2.start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus2.start = 1'b0;
            chk("w2_busy", 64'({bus2.busy, bus2.done}), 64'b10);
            @(negedge clk);
            chk("w2_done", 64'({bus2.busy, bus2.done}), 64'b01);
            chk("w2_result", 64'({bus2.cout, bus2.sum}), 64'(v[3:2] + v[1:0] + v[4]));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
